// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - PIC10F200 sequencer widths, opcode match tables and state type
package pic_pkg;

  localparam int PC_W = 9;
  localparam int IW   = 12;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    SLEEP = 2'd2
  } seq_state_t;

  // Each opcode is recognised by (ir & MASK) == VAL.
  localparam logic [IW-1:0] OP_GOTO_MASK   = 12'hE00;
  localparam logic [IW-1:0] OP_GOTO        = 12'hA00;
  localparam logic [IW-1:0] OP_CALL_MASK   = 12'hF00;
  localparam logic [IW-1:0] OP_CALL        = 12'h900;
  localparam logic [IW-1:0] OP_RETLW_MASK  = 12'hF00;
  localparam logic [IW-1:0] OP_RETLW       = 12'h800;
  localparam logic [IW-1:0] OP_SLEEP       = 12'h003;
  localparam logic [IW-1:0] OP_FSZ_MASK    = 12'hFC0;
  localparam logic [IW-1:0] OP_DECFSZ      = 12'h2C0;
  localparam logic [IW-1:0] OP_INCFSZ      = 12'h3C0;
  localparam logic [IW-1:0] OP_BTFS_MASK   = 12'hF00;
  localparam logic [IW-1:0] OP_BTFSC       = 12'h600;
  localparam logic [IW-1:0] OP_BTFSS       = 12'h700;

  function automatic logic op_match(input logic [IW-1:0] instr,
                                    input logic [IW-1:0] mask,
                                    input logic [IW-1:0] val);
    return (instr & mask) == val;
  endfunction

  function automatic logic is_skip_op(input logic [IW-1:0] instr);
    return op_match(instr, OP_FSZ_MASK, OP_DECFSZ) ||
           op_match(instr, OP_FSZ_MASK, OP_INCFSZ) ||
           op_match(instr, OP_BTFS_MASK, OP_BTFSC) ||
           op_match(instr, OP_BTFS_MASK, OP_BTFSS);
  endfunction

endpackage

// File: rtl/hw_stack2.sv
// rtl/hw_stack2.sv - two-entry hardware return stack with sticky overflow flag
module hw_stack2
  import pic_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] din,
  output logic [PC_W-1:0] top,
  output logic            ovf
);

  logic [PC_W-1:0] s0_q, s0_d;
  logic [PC_W-1:0] s1_q, s1_d;
  logic [1:0]      depth_q, depth_d;
  logic            ovf_q, ovf_d;

  always_comb begin
    s0_d    = s0_q;
    s1_d    = s1_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    if (push) begin
      s1_d = s0_q;
      s0_d = din;
      if (depth_q == 2'd2) ovf_d = 1'b1;
      else                 depth_d = depth_q + 2'd1;
    end else if (pop) begin
      // s1 keeps its value, so an underflowing pop still returns a stale address
      s0_d = s1_q;
      if (depth_q != 2'd0) depth_d = depth_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s0_q    <= '0;
      s1_q    <= '0;
      depth_q <= 2'd0;
      ovf_q   <= 1'b0;
    end else begin
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
    end
  end

  assign top = s0_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PIC10F200 instruction-cycle controller driving the PC register
module pc_sequencer
  import pic_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [IW-1:0]   prog_data,
  input  logic [PC_W-1:0] pc_cur,
  input  logic            skip_cond,
  input  logic            pcl_wr,
  input  logic [7:0]      pcl_data,
  input  logic            wake,
  output logic [IW-1:0]   ir,
  output logic            exec_valid,
  output logic            pc_inc,
  output logic            pc_load,
  output logic [PC_W-1:0] pc_mux_in,
  output logic            sleeping,
  output logic            stk_ovf
);

  seq_state_t      state_q, state_d;
  logic [IW-1:0]   ir_q, ir_d;
  logic            push, pop;
  logic [PC_W-1:0] stk_top;

  hw_stack2 u_stack (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .din  (pc_cur),
    .top  (stk_top),
    .ovf  (stk_ovf)
  );

  always_comb begin
    state_d    = state_q;
    ir_d       = prog_data;
    exec_valid = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    pc_mux_in  = '0;
    sleeping   = 1'b0;
    push       = 1'b0;
    pop        = 1'b0;
    case (state_q)
      FLUSH: begin
        pc_inc  = 1'b1;
        state_d = RUN;
      end
      SLEEP: begin
        // ir holds the word after SLEEP so it executes on the wake cycle
        sleeping = 1'b1;
        ir_d     = ir_q;
        if (wake) state_d = RUN;
      end
      RUN: begin
        exec_valid = 1'b1;
        if (op_match(ir_q, OP_GOTO_MASK, OP_GOTO)) begin
          pc_load   = 1'b1;
          pc_mux_in = ir_q[PC_W-1:0];
          state_d   = FLUSH;
        end else if (op_match(ir_q, OP_CALL_MASK, OP_CALL)) begin
          push      = 1'b1;
          pc_load   = 1'b1;
          pc_mux_in = {1'b0, ir_q[7:0]};
          state_d   = FLUSH;
        end else if (op_match(ir_q, OP_RETLW_MASK, OP_RETLW)) begin
          pop       = 1'b1;
          pc_load   = 1'b1;
          pc_mux_in = stk_top;
          state_d   = FLUSH;
        end else if (ir_q == OP_SLEEP) begin
          state_d = SLEEP;
        end else if (pcl_wr) begin
          pc_load   = 1'b1;
          pc_mux_in = {1'b0, pcl_data};
          state_d   = FLUSH;
        end else if (is_skip_op(ir_q) && skip_cond) begin
          pc_inc  = 1'b1;
          state_d = FLUSH;
        end else begin
          pc_inc = 1'b1;
        end
      end
      default: state_d = FLUSH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FLUSH;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  assign ir = ir_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed bench for pc_sequencer with program memory and PC register
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] prog_data;
  logic [8:0]  pc;
  logic        skip_cond;
  logic        pcl_wr;
  logic [7:0]  pcl_data;
  logic        wake;
  logic [11:0] ir;
  logic        exec_valid;
  logic        pc_inc;
  logic        pc_load;
  logic [8:0]  pc_mux_in;
  logic        sleeping;
  logic        stk_ovf;

  logic [11:0] mem [512];

  int nvec = 0;
  int nmiss = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .prog_data  (prog_data),
    .pc_cur     (pc),
    .skip_cond  (skip_cond),
    .pcl_wr     (pcl_wr),
    .pcl_data   (pcl_data),
    .wake       (wake),
    .ir         (ir),
    .exec_valid (exec_valid),
    .pc_inc     (pc_inc),
    .pc_load    (pc_load),
    .pc_mux_in  (pc_mux_in),
    .sleeping   (sleeping),
    .stk_ovf    (stk_ovf)
  );

  // PC register as it sits in the core
  always_ff @(posedge clk) begin
    if (rst)          pc <= 9'h000;
    else if (pc_load) pc <= pc_mux_in;
    else if (pc_inc)  pc <= pc + 9'd1;
  end

  assign prog_data = mem[pc];

  typedef struct {
    logic [11:0] instr;
    logic        skip;
    logic        pclw;
    logic [7:0]  pcld;
    logic        e_inc;
    logic        e_load;
    logic [8:0]  e_mux;
    logic        e_ev_next;
    logic        e_sleep;
  } vec_t;

  vec_t vecs [15];

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nmiss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 1 after reset (the flushed cycle), PC = 0.
  task automatic do_reset();
    rst       = 1'b1;
    skip_cond = 1'b0;
    pcl_wr    = 1'b0;
    pcl_data  = 8'h00;
    wake      = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 512; i++) mem[i] = 12'h000;
  endtask

  initial begin
    vecs[0]  = '{12'h000, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 9'h000, 1'b1, 1'b0};
    vecs[1]  = '{12'hBA5, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 9'h1A5, 1'b0, 1'b0};
    vecs[2]  = '{12'h940, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 9'h040, 1'b0, 1'b0};
    vecs[3]  = '{12'h9C3, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 9'h0C3, 1'b0, 1'b0};
    vecs[4]  = '{12'h855, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 9'h000, 1'b0, 1'b0};
    vecs[5]  = '{12'h003, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 9'h000, 1'b0, 1'b1};
    vecs[6]  = '{12'h025, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1, 9'h07F, 1'b0, 1'b0};
    vecs[7]  = '{12'h703, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 9'h000, 1'b0, 1'b0};
    vecs[8]  = '{12'h703, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 9'h000, 1'b1, 1'b0};
    vecs[9]  = '{12'h2C5, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 9'h000, 1'b0, 1'b0};
    vecs[10] = '{12'h3C5, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 9'h000, 1'b0, 1'b0};
    vecs[11] = '{12'h612, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 9'h000, 1'b0, 1'b0};
    vecs[12] = '{12'h285, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 9'h000, 1'b1, 1'b0};
    vecs[13] = '{12'hA10, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1, 9'h010, 1'b0, 1'b0};
    vecs[14] = '{12'h003, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b0, 9'h000, 1'b0, 1'b1};

    // Single-instruction decode table: word at 0x000 executes in cycle 2
    for (int v = 0; v < 15; v++) begin
      clear_mem();
      mem[0] = vecs[v].instr;
      do_reset();
      tick();
      skip_cond = vecs[v].skip;
      pcl_wr    = vecs[v].pclw;
      pcl_data  = vecs[v].pcld;
      #1;
      chk($sformatf("v%0d ir", v), ir, vecs[v].instr);
      chk($sformatf("v%0d exec_valid", v), exec_valid, 1);
      chk($sformatf("v%0d pc_inc", v), pc_inc, vecs[v].e_inc);
      chk($sformatf("v%0d pc_load", v), pc_load, vecs[v].e_load);
      if (vecs[v].e_load) chk($sformatf("v%0d pc_mux_in", v), pc_mux_in, vecs[v].e_mux);
      tick();
      skip_cond = 1'b0;
      pcl_wr    = 1'b0;
      pcl_data  = 8'h00;
      #1;
      chk($sformatf("v%0d next exec_valid", v), exec_valid, vecs[v].e_ev_next);
      chk($sformatf("v%0d next sleeping", v), sleeping, vecs[v].e_sleep);
    end

    // NOP stream from reset
    clear_mem();
    do_reset();
    chk("nop c1 exec_valid", exec_valid, 0);
    chk("nop c1 pc_inc", pc_inc, 1);
    chk("nop c1 pc", pc, 0);
    chk("nop c1 sleeping", sleeping, 0);
    chk("nop c1 stk_ovf", stk_ovf, 0);
    chk("nop c1 ir", ir, 0);
    for (int c = 2; c <= 6; c++) begin
      tick();
      chk($sformatf("nop c%0d exec_valid", c), exec_valid, 1);
      chk($sformatf("nop c%0d pc_inc", c), pc_inc, 1);
      chk($sformatf("nop c%0d pc_load", c), pc_load, 0);
    end
    chk("nop c6 pc", pc, 9'h005);

    // GOTO 0x1A5 at 0x003
    clear_mem();
    mem[3] = 12'hBA5; mem[4] = 12'h0AA; mem[9'h1A5] = 12'h025;
    do_reset();
    for (int c = 2; c <= 5; c++) tick();
    chk("goto pc", pc, 9'h004);
    chk("goto pc_load", pc_load, 1);
    chk("goto pc_inc", pc_inc, 0);
    chk("goto pc_mux_in", pc_mux_in, 9'h1A5);
    tick();
    chk("goto flush exec_valid", exec_valid, 0);
    chk("goto flush ir", ir, 12'h0AA);
    chk("goto flush pc", pc, 9'h1A5);
    chk("goto flush pc_load", pc_load, 0);
    tick();
    chk("goto target exec_valid", exec_valid, 1);
    chk("goto target ir", ir, 12'h025);

    // CALL 0x40 at 0x010, RETLW at 0x040
    clear_mem();
    mem[0] = 12'hA10; mem[9'h010] = 12'h940; mem[9'h011] = 12'h026; mem[9'h040] = 12'h800;
    do_reset();
    tick(); tick(); tick();
    chk("call pc", pc, 9'h011);
    chk("call pc_load", pc_load, 1);
    chk("call pc_mux_in", pc_mux_in, 9'h040);
    tick();
    chk("call flush exec_valid", exec_valid, 0);
    chk("call flush pc", pc, 9'h040);
    tick();
    chk("retlw ir", ir, 12'h800);
    chk("retlw pc_load", pc_load, 1);
    chk("retlw pc_mux_in", pc_mux_in, 9'h011);
    tick();
    chk("retlw flush exec_valid", exec_valid, 0);
    chk("retlw flush pc", pc, 9'h011);
    tick();
    chk("ret target exec_valid", exec_valid, 1);
    chk("ret target ir", ir, 12'h026);
    chk("ret stk_ovf", stk_ovf, 0);

    // Three nested CALLs overflow the stack
    clear_mem();
    mem[0] = 12'h910; mem[9'h010] = 12'h920; mem[9'h020] = 12'h930;
    mem[9'h030] = 12'h801; mem[9'h021] = 12'h802; mem[9'h011] = 12'h803;
    do_reset();
    for (int c = 2; c <= 6; c++) tick();
    chk("ovf third call pc_load", pc_load, 1);
    chk("ovf before third push", stk_ovf, 0);
    tick();
    chk("ovf after third push", stk_ovf, 1);
    tick();
    chk("ovf ret1 pc_mux_in", pc_mux_in, 9'h021);
    tick(); tick();
    chk("ovf ret2 pc_mux_in", pc_mux_in, 9'h011);
    tick(); tick();
    chk("ovf ret3 ir", ir, 12'h803);
    chk("ovf ret3 pc_mux_in", pc_mux_in, 9'h011);
    chk("ovf sticky", stk_ovf, 1);

    // BTFSS taken at 0x020
    clear_mem();
    mem[0] = 12'hA20; mem[9'h020] = 12'h703; mem[9'h021] = 12'h0AA; mem[9'h022] = 12'h0BB;
    do_reset();
    tick(); tick(); tick();
    skip_cond = 1'b1;
    #1;
    chk("skip pc_inc", pc_inc, 1);
    chk("skip pc_load", pc_load, 0);
    tick();
    skip_cond = 1'b0;
    #1;
    chk("skip flushed exec_valid", exec_valid, 0);
    chk("skip flushed ir", ir, 12'h0AA);
    chk("skip flushed pc", pc, 9'h022);
    tick();
    chk("skip resume exec_valid", exec_valid, 1);
    chk("skip resume ir", ir, 12'h0BB);

    // SLEEP at 0x030 then wake
    clear_mem();
    mem[0] = 12'hA30; mem[9'h030] = 12'h003; mem[9'h031] = 12'h026;
    do_reset();
    tick(); tick(); tick();
    chk("sleep instr pc_inc", pc_inc, 0);
    chk("sleep instr pc_load", pc_load, 0);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("sleep c%0d sleeping", c), sleeping, 1);
      chk($sformatf("sleep c%0d pc", c), pc, 9'h031);
      chk($sformatf("sleep c%0d exec_valid", c), exec_valid, 0);
    end
    wake = 1'b1;
    tick();
    wake = 1'b0;
    #1;
    chk("wake sleeping", sleeping, 0);
    chk("wake exec_valid", exec_valid, 1);
    chk("wake ir", ir, 12'h026);
    chk("wake pc_inc", pc_inc, 1);
    tick();
    chk("wake pc advance", pc, 9'h032);

    // Reset while sleeping
    do_reset();
    tick(); tick(); tick(); tick(); tick();
    chk("pre-rst sleeping", sleeping, 1);
    rst = 1'b1;
    tick();
    chk("rst in sleep pc", pc, 9'h000);
    chk("rst in sleep sleeping", sleeping, 0);
    chk("rst in sleep exec_valid", exec_valid, 0);
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmiss);
    $finish;
  end

endmodule
